// File: rtl/adc_packetizer_pkg.sv
// Shared types for the ADC packetizer: FSM states, FIFO entry layout, saturating increment.
package adc_packetizer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURE  = 2'd1,
      CLOSE    = 2'd2,
      WAIT_LOW = 2'd3
   } state_t;

   typedef struct packed {
      logic        user;
      logic        last;
      logic [31:0] data;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/adc_packetizer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible whenever not empty.
module sync_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_en && !full)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/adc_packetizer.sv
// Frames ADC words captured during the sync window into AXI4-Stream packets
// (tuser = first word, tlast = last word) through a FWFT output FIFO.
//
// state    | meaning
// IDLE     | waiting for sync to rise; valids ignored
// CAPTURE  | accepting words into the holding reg, pushing the previous one
// CLOSE    | pushing the held word with tlast once the FIFO has room
// WAIT_LOW | packet done; wait for sync low so a forced close cannot re-trigger
module adc_packetizer
   import adc_packetizer_pkg::*;
#(
   parameter int FIFO_DEPTH       = 16,
   parameter int MAX_PACKET_WORDS = 4096
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] adc_data,
   input  logic        adc_data_valid,
   input  logic        sync,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic [31:0] overflow_count,
   output logic [31:0] packet_count,
   output logic        busy
);

   localparam int CW = $clog2(MAX_PACKET_WORDS + 1);

   state_t      state;
   logic [31:0] held;
   logic        held_valid;
   logic        sof_pending;
   logic [CW-1:0] word_cnt;
   logic [CW-1:0] cnt_inc;

   logic        fifo_wr;
   logic        fifo_full;
   logic        fifo_empty;
   fifo_entry_t wr_entry;
   fifo_entry_t rd_entry;
   logic        accept;

   assign cnt_inc = word_cnt + 1'b1;
   assign accept  = (state == CAPTURE) && adc_data_valid && (!held_valid || !fifo_full);

   always_comb begin
      fifo_wr       = 1'b0;
      wr_entry.user = sof_pending;
      wr_entry.last = 1'b0;
      wr_entry.data = held;
      case (state)
         CAPTURE: fifo_wr = adc_data_valid && held_valid && !fifo_full;
         CLOSE: begin
            fifo_wr       = !fifo_full;
            wr_entry.last = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         held           <= '0;
         held_valid     <= 1'b0;
         sof_pending    <= 1'b0;
         word_cnt       <= '0;
         overflow_count <= '0;
         packet_count   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (sync) begin
                  state       <= CAPTURE;
                  word_cnt    <= '0;
                  held_valid  <= 1'b0;
                  sof_pending <= 1'b1;
               end
            end
            CAPTURE: begin
               if (accept) begin
                  held       <= adc_data;
                  held_valid <= 1'b1;
                  word_cnt   <= cnt_inc;
                  if (held_valid)
                     sof_pending <= 1'b0;
               end else if (adc_data_valid) begin
                  overflow_count <= sat_inc(overflow_count);
               end
               if (accept && (cnt_inc == CW'(MAX_PACKET_WORDS)))
                  state <= CLOSE;
               else if (!sync)
                  state <= (held_valid || accept) ? CLOSE : WAIT_LOW;
            end
            CLOSE: begin
               if (adc_data_valid && sync)
                  overflow_count <= sat_inc(overflow_count);
               if (!fifo_full) begin
                  held_valid   <= 1'b0;
                  packet_count <= sat_inc(packet_count);
                  state        <= WAIT_LOW;
               end
            end
            WAIT_LOW: begin
               if (adc_data_valid && sync)
                  overflow_count <= sat_inc(overflow_count);
               if (!sync)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (fifo_wr),
      .wr_data (wr_entry),
      .full    (fifo_full),
      .rd_en   (m_axis_tready),
      .rd_data (rd_entry),
      .empty   (fifo_empty)
   );

   // Head is only meaningful while valid; hold the bus at zero otherwise.
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_empty ? 32'd0 : rd_entry.data;
   assign m_axis_tlast  = !fifo_empty && rd_entry.last;
   assign m_axis_tuser  = !fifo_empty && rd_entry.user;
   assign busy          = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_adc_packetizer.sv
// Scoreboard bench for adc_packetizer: instance A uses default sizing, instance B a short max packet.
module tb_adc_packetizer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] adc_data = '0;
   logic        adc_data_valid = 1'b0;
   logic        sync = 1'b0;
   logic        tready = 1'b0;

   logic [31:0] a_tdata, b_tdata, a_ovf, b_ovf, a_pkt, b_pkt;
   logic        a_tvalid, b_tvalid, a_tlast, b_tlast, a_tuser, b_tuser, a_busy, b_busy;

   logic [33:0] exp_q [$];
   logic [33:0] obs_a [$];
   logic [33:0] obs_b [$];

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   adc_packetizer #(.FIFO_DEPTH(16), .MAX_PACKET_WORDS(4096)) dut_a (
      .clk(clk), .resetn(resetn), .adc_data(adc_data), .adc_data_valid(adc_data_valid),
      .sync(sync), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
      .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser), .overflow_count(a_ovf),
      .packet_count(a_pkt), .busy(a_busy));

   adc_packetizer #(.FIFO_DEPTH(16), .MAX_PACKET_WORDS(8)) dut_b (
      .clk(clk), .resetn(resetn), .adc_data(adc_data), .adc_data_valid(adc_data_valid),
      .sync(sync), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
      .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser), .overflow_count(b_ovf),
      .packet_count(b_pkt), .busy(b_busy));

   // Inputs change 1 ns after posedge, so negedge values are those the next posedge sees.
   always @(negedge clk) begin
      if (resetn && tready && a_tvalid) obs_a.push_back({a_tuser, a_tlast, a_tdata});
      if (resetn && tready && b_tvalid) obs_b.push_back({b_tuser, b_tlast, b_tdata});
   end

   task automatic step(input logic s, input logic v, input logic [31:0] d);
      sync = s; adc_data_valid = v; adc_data = d;
      @(posedge clk); #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      resetn = 1'b0; tready = 1'b0; sync = 1'b0; adc_data_valid = 1'b0; adc_data = '0;
      wait_cyc(2);
      resetn = 1'b1;
      wait_cyc(1);
      exp_q.delete(); obs_a.delete(); obs_b.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (a_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", a_tvalid); else n_pass++;
      n_chk++; if ({a_tuser, a_tlast} !== 2'b00) $display("FAIL reset_user_last: got %b want 00", {a_tuser, a_tlast}); else n_pass++;
      n_chk++; if (a_tdata !== 32'd0) $display("FAIL reset_tdata: got %h want 0", a_tdata); else n_pass++;
      n_chk++; if (a_ovf !== 32'd0 || a_pkt !== 32'd0) $display("FAIL reset_counters: got %h/%h want 0/0", a_ovf, a_pkt); else n_pass++;
      n_chk++; if (a_busy !== 1'b0 || b_busy !== 1'b0) $display("FAIL reset_busy: got %b%b want 00", a_busy, b_busy); else n_pass++;
   endtask

   task automatic test_basic();
      logic [33:0] e, o;
      do_reset();
      tready = 1'b1;
      step(1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({(k == 0), (k == 3), 32'hA000_0000 + k});
         step(1, 1, 32'hA000_0000 + k);
      end
      repeat (5) step(1, 0, 0);
      step(0, 0, 0);
      for (int c = 0; c < 100 && obs_a.size() < exp_q.size(); c++) wait_cyc(1);
      wait_cyc(5);
      n_chk++; if (obs_a.size() != exp_q.size()) $display("FAIL basic_beats: got %0d want %0d", obs_a.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_a.size() > 0) begin
         e = exp_q.pop_front(); o = obs_a.pop_front();
         n_chk++; if (o !== e) $display("FAIL basic_beat: got %h want %h", o, e); else n_pass++;
      end
      n_chk++; if (a_pkt !== 32'd1) $display("FAIL basic_pkt: got %0d want 1", a_pkt); else n_pass++;
      n_chk++; if (a_ovf !== 32'd0) $display("FAIL basic_ovf: got %0d want 0", a_ovf); else n_pass++;
      n_chk++; if (a_busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", a_busy); else n_pass++;
   endtask

   task automatic test_max_packet();
      logic [33:0] e, o;
      do_reset();
      tready = 1'b1;
      step(1, 0, 0);
      for (int k = 0; k < 20; k++) begin
         if (k < 8) exp_q.push_back({(k == 0), (k == 7), 32'hB000_0000 + k});
         step(1, 1, 32'hB000_0000 + k);
      end
      repeat (6) step(1, 0, 0);
      n_chk++; if (obs_b.size() != 8) $display("FAIL max_beats: got %0d want 8", obs_b.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_b.size() > 0) begin
         e = exp_q.pop_front(); o = obs_b.pop_front();
         n_chk++; if (o !== e) $display("FAIL max_beat: got %h want %h", o, e); else n_pass++;
      end
      exp_q.delete(); obs_b.delete();
      n_chk++; if (b_ovf !== 32'd12) $display("FAIL max_ovf: got %0d want 12", b_ovf); else n_pass++;
      n_chk++; if (b_pkt !== 32'd1) $display("FAIL max_pkt: got %0d want 1", b_pkt); else n_pass++;
      step(0, 0, 0); step(0, 0, 0);
      step(1, 0, 0);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back({(k == 0), (k == 1), 32'hB100_0000 + k});
         step(1, 1, 32'hB100_0000 + k);
      end
      step(0, 0, 0);
      for (int c = 0; c < 100 && obs_b.size() < exp_q.size(); c++) wait_cyc(1);
      wait_cyc(5);
      n_chk++; if (obs_b.size() != exp_q.size()) $display("FAIL max_rearm_beats: got %0d want %0d", obs_b.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_b.size() > 0) begin
         e = exp_q.pop_front(); o = obs_b.pop_front();
         n_chk++; if (o !== e) $display("FAIL max_rearm_beat: got %h want %h", o, e); else n_pass++;
      end
      n_chk++; if (b_pkt !== 32'd2) $display("FAIL max_rearm_pkt: got %0d want 2", b_pkt); else n_pass++;
   endtask

   task automatic test_overflow();
      logic [33:0] e, o;
      do_reset();
      step(1, 0, 0);
      for (int k = 0; k < 30; k++) begin
         if (k < 17) exp_q.push_back({(k == 0), (k == 16), 32'hC000_0000 + k});
         step(1, 1, 32'hC000_0000 + k);
      end
      repeat (3) step(0, 0, 0);
      n_chk++; if (a_ovf !== 32'd13) $display("FAIL ovf_count: got %0d want 13", a_ovf); else n_pass++;
      n_chk++; if ({a_tvalid, a_tuser, a_tdata} !== {2'b11, 32'hC000_0000})
         $display("FAIL ovf_stall_head: got %b%b %h want 11 c0000000", a_tvalid, a_tuser, a_tdata); else n_pass++;
      n_chk++; if (a_pkt !== 32'd0 || a_busy !== 1'b1) $display("FAIL ovf_stall_state: got pkt %0d busy %b want 0 1", a_pkt, a_busy); else n_pass++;
      tready = 1'b1;
      for (int c = 0; c < 200 && obs_a.size() < exp_q.size(); c++) wait_cyc(1);
      wait_cyc(5);
      n_chk++; if (obs_a.size() != exp_q.size()) $display("FAIL ovf_beats: got %0d want %0d", obs_a.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_a.size() > 0) begin
         e = exp_q.pop_front(); o = obs_a.pop_front();
         n_chk++; if (o !== e) $display("FAIL ovf_beat: got %h want %h", o, e); else n_pass++;
      end
      n_chk++; if (a_pkt !== 32'd1 || a_ovf !== 32'd13) $display("FAIL ovf_final: got pkt %0d ovf %0d want 1 13", a_pkt, a_ovf); else n_pass++;
   endtask

   task automatic test_empty_window();
      do_reset();
      tready = 1'b1;
      repeat (5) step(1, 0, 0);
      repeat (4) step(0, 0, 0);
      n_chk++; if (obs_a.size() != 0) $display("FAIL empty_beats: got %0d want 0", obs_a.size()); else n_pass++;
      n_chk++; if (a_pkt !== 32'd0) $display("FAIL empty_pkt: got %0d want 0", a_pkt); else n_pass++;
      n_chk++; if (a_busy !== 1'b0) $display("FAIL empty_idle: got busy %b want 0", a_busy); else n_pass++;
   endtask

   task automatic test_single_word();
      logic [33:0] o;
      do_reset();
      tready = 1'b1;
      step(1, 0, 0);
      exp_q.push_back({2'b11, 32'hD00D_0001});
      step(0, 1, 32'hD00D_0001);
      for (int c = 0; c < 50 && obs_a.size() < 1; c++) wait_cyc(1);
      wait_cyc(4);
      n_chk++; if (obs_a.size() != 1) $display("FAIL single_beats: got %0d want 1", obs_a.size()); else n_pass++;
      if (obs_a.size() > 0) begin
         o = obs_a.pop_front();
         n_chk++; if (o !== exp_q[0]) $display("FAIL single_beat: got %h want %h", o, exp_q[0]); else n_pass++;
      end
      n_chk++; if (a_pkt !== 32'd1) $display("FAIL single_pkt: got %0d want 1", a_pkt); else n_pass++;
   endtask

   task automatic test_reset_mid_packet();
      logic [33:0] e, o;
      do_reset();
      step(1, 0, 0);
      for (int k = 0; k < 9; k++) step(1, 1, 32'hE000_0000 + k);
      n_chk++; if (a_tvalid !== 1'b1) $display("FAIL rst_mid_pre_tvalid: got %b want 1", a_tvalid); else n_pass++;
      resetn = 1'b0;
      #1;
      n_chk++; if (a_tvalid !== 1'b0 || a_busy !== 1'b0) $display("FAIL rst_mid_outputs: got tvalid %b busy %b want 0 0", a_tvalid, a_busy); else n_pass++;
      n_chk++; if (a_ovf !== 32'd0 || a_pkt !== 32'd0) $display("FAIL rst_mid_counters: got %0d/%0d want 0/0", a_ovf, a_pkt); else n_pass++;
      sync = 1'b0; adc_data_valid = 1'b0;
      wait_cyc(2);
      resetn = 1'b1;
      wait_cyc(1);
      exp_q.delete(); obs_a.delete(); obs_b.delete();
      tready = 1'b1;
      step(1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back({(k == 0), (k == 2), 32'hF000_0000 + k});
         step(1, 1, 32'hF000_0000 + k);
      end
      step(0, 0, 0);
      for (int c = 0; c < 100 && obs_a.size() < exp_q.size(); c++) wait_cyc(1);
      wait_cyc(5);
      n_chk++; if (obs_a.size() != exp_q.size()) $display("FAIL rst_mid_beats: got %0d want %0d", obs_a.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_a.size() > 0) begin
         e = exp_q.pop_front(); o = obs_a.pop_front();
         n_chk++; if (o !== e) $display("FAIL rst_mid_beat: got %h want %h", o, e); else n_pass++;
      end
      n_chk++; if (a_pkt !== 32'd1) $display("FAIL rst_mid_pkt: got %0d want 1", a_pkt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_packet();
      test_overflow();
      test_empty_window();
      test_single_word();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
